// File: rtl/eth_pkg.sv
// Shared Ethernet constants and transmit sequencer state encoding.
// Used by the TX sequencer and the CRC-32 datapath.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_POLY_REFL = 32'hEDB88320;

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_PREAMBLE = 3'd1,
        TX_SFD      = 3'd2,
        TX_PAYLOAD  = 3'd3,
        TX_PAD      = 3'd4,
        TX_FCS      = 3'd5,
        TX_IFG      = 3'd6
    } tx_state_e;

endpackage

// File: rtl/mac_tx_ctrl_if.sv
// Byte-stream payload handshake feeding the MAC transmit sequencer.
// The source drives data/valid/last; the MAC returns ready.
interface mac_tx_ctrl_if;

    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );

endinterface

// File: rtl/crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 (reflected) update for one data byte.
// Shared by the TX FCS generator and the RX FCS checker.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] i_crc_in,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_next
);

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc_in ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            if (w_c[0]) begin
                w_c = (w_c >> 1) ^ ETH_CRC_POLY_REFL;
            end else begin
                w_c = w_c >> 1;
            end
        end
        o_crc_next = w_c;
    end

endmodule

// File: rtl/mac_tx_ctrl.sv
// Gigabit MAC transmit sequencer: preamble, SFD, payload, FCS and IFG.
// Define MAC_TX_PAD_EN to zero-pad short frames to MIN_FRAME bytes.
module mac_tx_ctrl
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
`ifdef MAC_TX_PAD_EN
    ,
    parameter int MIN_FRAME    = 60
`endif
) (
    input  logic        clk,
    input  logic        rst,
    mac_tx_ctrl_if.slave s_if,
    output logic        mac_phy_txen,
    output logic [7:0]  mac_phy_txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_underrun
);

    localparam logic [2:0] S_IDLE     = TX_IDLE;
    localparam logic [2:0] S_PREAMBLE = TX_PREAMBLE;
    localparam logic [2:0] S_SFD      = TX_SFD;
    localparam logic [2:0] S_PAYLOAD  = TX_PAYLOAD;
    localparam logic [2:0] S_FCS      = TX_FCS;
    localparam logic [2:0] S_IFG      = TX_IFG;
`ifdef MAC_TX_PAD_EN
    localparam logic [2:0]  S_PAD = TX_PAD;
    localparam logic [15:0] L_MIN = 16'(MIN_FRAME);
`endif
    localparam logic [15:0] L_PRE_LAST = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] L_IFG_LAST = 16'(IFG_CYCLES - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_crc;
    logic        r_txen;
    logic [7:0]  r_txd;
    logic        r_done;
    logic        r_underrun;

    logic [7:0]  w_crc_din;
    logic [31:0] w_crc_next;
    logic [15:0] w_cnt_inc;
    logic [7:0]  w_fcs_byte;

    // Pad bytes are zeros; only PAYLOAD feeds real data into the CRC.
    assign w_crc_din = (r_state == S_PAYLOAD) ? s_if.s_tdata : 8'h00;
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    crc32_d8 u_crc (
        .i_crc_in   (r_crc),
        .i_data     (w_crc_din),
        .o_crc_next (w_crc_next)
    );

    always_comb begin
        unique case (r_cnt[1:0])
            2'd0: w_fcs_byte = ~r_crc[7:0];
            2'd1: w_fcs_byte = ~r_crc[15:8];
            2'd2: w_fcs_byte = ~r_crc[23:16];
            2'd3: w_fcs_byte = ~r_crc[31:24];
        endcase
    end

    assign s_if.s_tready = (r_state == S_PAYLOAD);
    assign tx_busy       = (r_state != S_IDLE);
    assign mac_phy_txen  = r_txen;
    assign mac_phy_txd   = r_txd;
    assign tx_done       = r_done;
    assign tx_underrun   = r_underrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_crc      <= ETH_CRC_INIT;
            r_txen     <= 1'b0;
            r_txd      <= 8'h00;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_txen <= 1'b0;
                    r_txd  <= 8'h00;
                    if (s_if.s_tvalid) begin
                        r_state <= S_PREAMBLE;
                        r_txen  <= 1'b1;
                        r_txd   <= ETH_PREAMBLE_BYTE;
                        r_cnt   <= 16'd1;
                    end
                end
                S_PREAMBLE: begin
                    r_txd <= ETH_PREAMBLE_BYTE;
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt == L_PRE_LAST) begin
                        r_state <= S_SFD;
                        r_cnt   <= 16'd0;
                    end
                end
                S_SFD: begin
                    r_txd   <= ETH_SFD_BYTE;
                    r_state <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (s_if.s_tvalid) begin
                        r_txd <= s_if.s_tdata;
                        r_crc <= w_crc_next;
                        r_cnt <= w_cnt_inc;
                        if (s_if.s_tlast) begin
`ifdef MAC_TX_PAD_EN
                            if (w_cnt_inc < L_MIN) r_state <= S_PAD;
                            else
`endif
                            begin
                                r_state <= S_FCS;
                                r_cnt   <= 16'd0;
                            end
                        end
                    end else begin
                        // Source starved: truncate, skip FCS.
                        r_txen     <= 1'b0;
                        r_txd      <= 8'h00;
                        r_underrun <= 1'b1;
                        r_crc      <= ETH_CRC_INIT;
                        r_cnt      <= 16'd0;
                        r_state    <= S_IFG;
                    end
                end
`ifdef MAC_TX_PAD_EN
                S_PAD: begin
                    r_txd <= 8'h00;
                    r_crc <= w_crc_next;
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt + 16'd1 == L_MIN) begin
                        r_state <= S_FCS;
                        r_cnt   <= 16'd0;
                    end
                end
`endif
                S_FCS: begin
                    r_txd <= w_fcs_byte;
                    r_cnt <= r_cnt + 16'd1;
                    if (r_cnt[1:0] == 2'd3) begin
                        r_done  <= 1'b1;
                        r_crc   <= ETH_CRC_INIT;
                        r_cnt   <= 16'd0;
                        r_state <= S_IFG;
                    end
                end
                S_IFG: begin
                    r_txen <= 1'b0;
                    r_txd  <= 8'h00;
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt == L_IFG_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                    r_txen  <= 1'b0;
                    r_txd   <= 8'h00;
                end
            endcase
        end
    end

endmodule
